// File: rtl/wb_frame_arbiter.sv
// Round-robin arbiter that serialises several Wishbone masters onto one slave port.
// States: IDLE | no grant, choose the next requester / GRANT | slave port owned by gidx_q / RELEASE | one forced idle bus cycle
module wb_frame_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_HOLD      = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [ADDRESS_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic                                 s_we_o,
    output logic [DATA_BYTES-1:0]                s_sel_o,
    output logic                                 s_stb_o,
    output logic                                 s_cyc_o,
    output logic [2:0]                           s_cti_o,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                 s_ack_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 busy_o
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int SCN_W = PTR_W + 1;
    localparam int WD_W  = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [WD_W-1:0]        wd_q, wd_d;

    logic                   pick_found;
    logic [PTR_W-1:0]       pick_idx;
    logic [SCN_W-1:0]       scan;
    logic [PTR_W-1:0]       rr_next;
    logic                   gnt_cyc;
    logic                   wd_fire;

    assign gnt_cyc = m_cyc_i[gidx_q];
    // An ack in the terminal cycle wins over the abort.
    assign wd_fire = (state_q == GRANT) && (wd_q == WD_W'(MAX_HOLD - 1)) && !s_ack_i;
    assign rr_next = (gidx_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + PTR_W'(1);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            scan = {1'b0, rr_q} + SCN_W'(i);
            if (scan >= SCN_W'(NUM_MASTERS)) begin
                scan = scan - SCN_W'(NUM_MASTERS);
            end
            if (!pick_found && m_cyc_i[scan[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    wd_d    = '0;
                end
            end
            GRANT: begin
                wd_d = s_ack_i ? '0 : wd_q + WD_W'(1);
                if (!gnt_cyc || wd_fire) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    rr_d    = rr_next;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_cti_o = 3'b000;
        m_ack_o = '0;
        m_err_o = '0;
        busy_o  = 1'b0;
        if (state_q == GRANT) begin
            s_adr_o = m_adr_i[gidx_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_dat_o = m_dat_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
            s_we_o  = m_we_i[gidx_q];
            s_sel_o = m_sel_i[gidx_q*DATA_BYTES +: DATA_BYTES];
            s_stb_o = m_stb_i[gidx_q];
            s_cyc_o = gnt_cyc;
            s_cti_o = m_cti_i[gidx_q*3 +: 3];
            m_ack_o = s_ack_i ? grant_q : '0;
            m_err_o = wd_fire ? grant_q : '0;
            busy_o  = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_frame_arbiter.sv
// Directed bench for wb_frame_arbiter: expected grant order is queued when requests are raised
// and compared each time the arbiter hands out a new grant.
module tb_wb_frame_arbiter;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DB = 1;
    localparam int MH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM-1:0]     m_we;
    logic [NM*DB-1:0]  m_sel;
    logic [NM-1:0]     m_stb;
    logic [NM-1:0]     m_cyc;
    logic [NM*3-1:0]   m_cti;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_we_o;
    logic [DB-1:0]     s_sel_o;
    logic              s_stb_o;
    logic              s_cyc_o;
    logic [2:0]        s_cti_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack;
    logic [NM-1:0]     grant_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic [NM-1:0] prev_gnt = '0;

    wb_frame_arbiter #(
        .NUM_MASTERS  (NM),
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DATA_BYTES   (DB),
        .MAX_HOLD     (MH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m_adr_i(m_adr),
        .m_dat_i(m_dat),
        .m_we_i (m_we),
        .m_sel_i(m_sel),
        .m_stb_i(m_stb),
        .m_cyc_i(m_cyc),
        .m_cti_i(m_cti),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_we_o (s_we_o),
        .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o),
        .s_cti_o(s_cti_o),
        .s_dat_i(s_dat),
        .s_ack_i(s_ack),
        .grant_o(grant_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every fresh grant must match the next queued master index.
    always @(negedge clk) begin
        if (grant_o != '0 && prev_gnt == '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL grant_unexpected observed=%0h expected=none", grant_o);
            end else begin
                check("grant_order", grant_o, 4'b0001 << exp_q.pop_front());
            end
        end
        prev_gnt = grant_o;
    end

    task automatic set_m(input int k, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [2:0] cti);
        m_cyc[k]          = 1'b1;
        m_stb[k]          = 1'b1;
        m_we[k]           = we;
        m_sel[k]          = 1'b1;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_cti[k*3 +: 3]   = cti;
    endtask

    task automatic drop(input int k);
        m_cyc[k] = 1'b0;
        m_stb[k] = 1'b0;
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0;
        m_stb = '0; m_cyc = '0; m_cti = '0;
        s_ack = 1'b0; s_dat = '0;
    endtask

    task automatic apply_reset();
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grant_o == '0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check(tag, grant_o != '0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("rst_outputs", {s_cyc_o, s_stb_o, busy_o, grant_o, m_ack_o, m_err_o, s_adr_o}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {s_cyc_o, s_stb_o, busy_o, grant_o, m_ack_o, m_err_o}, 0);
        end

        // single master write, ack three cycles after grant
        set_m(1, 1'b1, 16'h0412, 8'hA5, 3'b000);
        exp_q.push_back(1);
        @(negedge clk);
        check("single_grant", grant_o, 4'b0010);
        check("single_adr", s_adr_o, 16'h0412);
        check("single_dat", s_dat_o, 8'hA5);
        check("single_we_cyc_stb", {s_we_o, s_cyc_o, s_stb_o}, 3'b111);
        check("single_no_ack", m_ack_o, 4'b0000);
        repeat (2) @(negedge clk);
        s_ack = 1'b1;
        #1 check("single_ack", m_ack_o, 4'b0010);
        @(negedge clk);
        s_ack = 1'b0;
        drop(1);
        #1 check("single_ack_off", m_ack_o, 4'b0000);
        check("single_cyc_drop", s_cyc_o, 1'b0);
        @(negedge clk);
        check("single_release", {busy_o, grant_o}, 0);

        // round robin with everyone requesting
        apply_reset();
        for (int k = 0; k < NM; k++) set_m(k, 1'b0, 16'h1000 + 16'(k), 8'h00, 3'b000);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int t = 0; t < 5; t++) begin
            wait_grant("rr_grant");
            s_ack = 1'b1;
            s_dat = 8'h50 + 8'(t);
            #1 check("rr_ack", m_ack_o, 4'b0001 << (t % NM));
            check("rr_rdata", m_dat_o, 8'h50 + 8'(t));
            @(negedge clk);
            s_ack = 1'b0;
            drop(t % NM);
            @(negedge clk);
            check("rr_gap", {s_cyc_o, grant_o}, 0);
            if (t < 4) set_m(t % NM, 1'b0, 16'h1000 + 16'(t % NM), 8'h00, 3'b000);
            else m_cyc = '0;
        end
        m_stb = '0;

        // burst hold by master 2 while master 0 waits
        apply_reset();
        set_m(2, 1'b1, 16'h2000, 8'h22, 3'b010);
        exp_q.push_back(2);
        wait_grant("burst_grant");
        set_m(0, 1'b0, 16'h0100, 8'h00, 3'b000);
        exp_q.push_back(0);
        for (int b = 0; b < 4; b++) begin
            m_cti[2*3 +: 3]   = (b == 3) ? 3'b111 : 3'b010;
            m_adr[2*AW +: AW] = 16'h2000 + 16'(b);
            s_ack = 1'b1;
            #1 check("burst_ack", m_ack_o, 4'b0100);
            check("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
            check("burst_adr", s_adr_o, 16'h2000 + 16'(b));
            @(negedge clk);
        end
        s_ack = 1'b0;
        m_stb[2] = 1'b0;
        #1 check("burst_hold", grant_o, 4'b0100);
        @(negedge clk);
        check("burst_hold2", grant_o, 4'b0100);
        drop(2);
        @(negedge clk);
        check("burst_release", {s_cyc_o, grant_o}, 0);
        wait_grant("burst_next");
        s_ack = 1'b1;
        #1 check("m0_ack", m_ack_o, 4'b0001);
        @(negedge clk);
        s_ack = 1'b0;
        drop(0);
        @(negedge clk);

        // watchdog abort on master 1, then master 3 must come before master 1 again
        set_m(1, 1'b0, 16'h0555, 8'h00, 3'b000);
        exp_q.push_back(1);
        wait_grant("wd_grant");
        for (int c = 1; c <= 8; c++) begin
            check("wd_err", m_err_o, (c == 8) ? 4'b0010 : 4'b0000);
            if (c < 8) @(negedge clk);
        end
        set_m(3, 1'b0, 16'h0333, 8'h00, 3'b000);
        exp_q.push_back(3);
        exp_q.push_back(1);
        @(negedge clk);
        check("wd_release", {s_cyc_o, grant_o, m_err_o}, 0);
        wait_grant("wd_rr");
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        drop(3);
        @(negedge clk);
        wait_grant("wd_fresh");
        for (int c = 1; c < 8; c++) begin
            check("wd2_err", m_err_o, 4'b0000);
            @(negedge clk);
        end
        s_ack = 1'b1;
        #1 check("wd_ack_err", m_err_o, 4'b0000);
        check("wd_ack_ack", m_ack_o, 4'b0010);
        @(negedge clk);
        s_ack = 1'b0;
        #1 check("wd_ack_hold", {grant_o, m_err_o}, {4'b0010, 4'b0000});
        drop(1);
        @(negedge clk);
        check("wd2_release", grant_o, 4'b0000);

        // async reset in the middle of master 3's burst
        set_m(3, 1'b1, 16'h0F00, 8'h77, 3'b010);
        exp_q.push_back(3);
        wait_grant("ar_grant");
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("ar_drop", {s_cyc_o, s_stb_o, busy_o, grant_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_m(0, 1'b0, 16'h0000, 8'h00, 3'b000);
        exp_q.push_back(0);
        exp_q.push_back(3);
        wait_grant("ar_grant0");
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        drop(0);
        @(negedge clk);
        wait_grant("ar_grant3");
        drop(3);
        repeat (3) @(negedge clk);

        check("queue_final", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_frame_arbiter.md
Name: wb_frame_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one downstream Wishbone slave port between NUM_MASTERS pattern/animation generators.
- The slave port is typically the frame-buffer RAM and matrix-register interconnect.
- Each generator keeps its own wishbone_master; this block serialises their cycles, routes ack/data back to the granted master, and aborts a hung cycle with a watchdog.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- ADDRESS_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- DATA_BYTES, 1, byte-select width.
- MAX_HOLD, 1024, cycles without s_ack_i before the granted cycle is aborted (must be ≥2).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed master addresses; master k at slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*DATA_BYTES  packed byte selects.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type identifiers.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  ack, granted master only.
- m_err_o  out  NUM_MASTERS  watchdog abort pulse, granted master only.
- s_adr_o  out  ADDRESS_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  DATA_BYTES  slave byte select.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_cti_o  out  3  slave cycle type.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  NUM_MASTERS  registered one-hot grant.
- busy_o  out  1  high in GRANT state.

Behaviour:
- Clock and reset:
  - Single clock domain, clk_i.
  - rst_ni low asynchronously clears state to IDLE, grant_o=0, rr_ptr=0, watchdog=0.
  - While rst_ni is low, all s_* outputs, m_ack_o, m_err_o and busy_o are 0.
  - Reset asserted mid-cycle drops s_cyc_o/s_stb_o immediately. No completion is reported.
- State machine: IDLE, GRANT, RELEASE.
- IDLE:
  - If any m_cyc_i is set, pick the first requester at or after rr_ptr, scanning upward with wrap modulo NUM_MASTERS.
  - Register its one-hot grant and go to GRANT.
  - Latency: cyc sampled at edge N gives grant_o and s_cyc_o high after edge N.
- GRANT:
  - s_* outputs are combinational muxes of the granted master's slices.
  - s_cyc_o = granted m_cyc_i; s_stb_o = granted m_stb_i.
  - m_ack_o[g] = s_ack_i; all other m_ack_o bits are 0.
  - m_dat_o = s_dat_i at all times.
  - Grant is held while granted m_cyc_i=1, including multi-beat bursts (cti 010). cti=111 alone does not release.
  - Granted m_cyc_i=0 sampled: go to RELEASE; rr_ptr = (g+1) mod NUM_MASTERS.
- Watchdog:
  - Counter is cleared on entry to GRANT and on every s_ack_i.
  - Otherwise it increments each GRANT cycle.
  - On reaching MAX_HOLD-1 with no ack: m_err_o[g]=1 for exactly one cycle, next state RELEASE, rr_ptr advances as for a normal release.
  - The faulting master must drop cyc. If it still holds cyc in IDLE it is treated as a fresh request, but only after the higher-ptr requesters.
- RELEASE:
  - One cycle; s_cyc_o=0, s_stb_o=0, grant_o=0. Then go to IDLE.
  - This guarantees at least one idle bus cycle between different masters' cycles.
  - Back-to-back grants to the same master are separated by at least 2 cycles.
- Non-granted masters: a master raising m_cyc_i while another holds the grant sees no ack and simply waits. No request queueing beyond the level of m_cyc_i.
- Simultaneous events:
  - Granted master drops cyc in the same cycle another raises it: RELEASE first, the new grant is decided in IDLE.
  - s_ack_i in the same cycle the watchdog would fire: the ack wins, the counter clears, no error.
- Fairness: with all masters requesting continuously, grants cycle 0,1,2,3,0,... No master waits more than NUM_MASTERS-1 tenures.

Test Plan:
- Reset/idle: rst_ni=0 then 1 with no m_cyc_i → all outputs 0, grant_o=0 for 20 cycles.
- Single master:
  - m_cyc_i=0010 writes adr 0x0412, dat 0xA5, we=1; slave acks after 3 cycles.
  - Required: grant_o=0010 one cycle after the request, s_adr_o=0x0412, s_dat_o=0xA5.
  - m_ack_o=0010 exactly on the ack cycle; RELEASE follows cyc drop.
- Round-robin: all four m_cyc_i held high, each master drops cyc after one acked transfer → grant order 0,1,2,3,0. One s_cyc_o=0 cycle between each grant.
- Burst hold:
  - Master 2 issues a 4-beat burst (cti 010,010,010,111) while master 0 requests.
  - Required: master 2 keeps the grant across all 4 acks; master 0 is granted only after master 2 drops cyc.
- Watchdog:
  - MAX_HOLD=8; master 1 granted, slave never acks.
  - Required: m_err_o=0010 for one cycle on the 8th GRANT cycle, then s_cyc_o=0 and rr_ptr=2.
  - Repeat with s_ack_i on cycle 8 → no err.
- Async reset mid-burst: rst_ni low during master 3's GRANT → s_cyc_o and grant_o go 0 without a clock edge. After release, master 0 wins over master 3 when both request.
